pi1dcd: RTL and testbench

Single-master to multi-slave address decoder for the peripheral interconnect. It sits directly downstream of the multi-master arbitration queue and takes that queue's single slave-side request stream. It routes each op to the slave whose address window contains it, rebased to a window-relative address, and returns that slave's read data one transaction later. Ops that miss every window complete immediately with zero data, and the block records the missing address.

---
 rtl/pi1dcd_pkg.sv | 21 ++
 rtl/pi1dcd_if.sv | 42 ++++
 rtl/pi1dcd_match.sv | 16 +
 rtl/pi1dcd.sv | 108 ++++++++++
 tb/tb_pi1dcd.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pi1dcd_pkg.sv
// Shared definitions for the peripheral interconnect: op encodings and a
// constant-evaluable clog2 also used by the arbitration queue.
package pi1dcd_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pi1dcd_if.sv
// Request/response bus between the arbitration queue, the decoder and the
// slave ports; slave-side vectors are flattened, slave i at slice i.
interface pi1dcd_if
  import pi1dcd_pkg::*;
#(
  parameter int unsigned SLAVECOUNT = 2,
  parameter int unsigned ARCHBITSZ  = 32
) ();

  localparam int unsigned ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);
  localparam int unsigned SELBITSZ  = ARCHBITSZ / 8;

  logic [1:0]                      m_op_i;
  logic [ADDRBITSZ-1:0]            m_addr_i;
  logic [ARCHBITSZ-1:0]            m_data_i;
  logic [SELBITSZ-1:0]             m_sel_i;
  logic [ARCHBITSZ-1:0]            m_data_o;
  logic                            m_rdy_o;
  logic [2*SLAVECOUNT-1:0]         s_op_o_flat;
  logic [ADDRBITSZ*SLAVECOUNT-1:0] s_addr_o_flat;
  logic [ARCHBITSZ*SLAVECOUNT-1:0] s_data_o_flat;
  logic [SELBITSZ*SLAVECOUNT-1:0]  s_sel_o_flat;
  logic [ARCHBITSZ*SLAVECOUNT-1:0] s_data_i_flat;
  logic [SLAVECOUNT-1:0]           s_rdy_i_flat;
  logic                            err_o;
  logic [ADDRBITSZ-1:0]            erraddr_o;

  // Environment side: upstream master plus the slave peripherals.
  modport master (
    output m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i_flat, s_rdy_i_flat,
    input  m_data_o, m_rdy_o, s_op_o_flat, s_addr_o_flat, s_data_o_flat,
           s_sel_o_flat, err_o, erraddr_o
  );

  // Decoder side.
  modport slave (
    input  m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i_flat, s_rdy_i_flat,
    output m_data_o, m_rdy_o, s_op_o_flat, s_addr_o_flat, s_data_o_flat,
           s_sel_o_flat, err_o, erraddr_o
  );

endinterface

// File: rtl/pi1dcd_match.sv
// Window match for one slave: unsigned offset from base compared with size,
// so windows wrapping past the top of the address space still match.
module pi1dcd_match #(
  parameter int unsigned ADDRBITSZ = 30
) (
  input  logic [ADDRBITSZ-1:0] addr,
  input  logic [ADDRBITSZ-1:0] base,
  input  logic [ADDRBITSZ-1:0] size,
  output logic                 hit,
  output logic [ADDRBITSZ-1:0] rebased
);

  assign rebased = addr - base;
  assign hit     = (rebased < size);

endmodule

// File: rtl/pi1dcd.sv
// Single-master to multi-slave address decoder: routes each op to the
// lowest-index matching window and returns data one accepted op later.
module pi1dcd
  import pi1dcd_pkg::*;
#(
  parameter int unsigned SLAVECOUNT = 2,
  parameter int unsigned ARCHBITSZ  = 32,
  localparam int unsigned ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  parameter logic [ADDRBITSZ*SLAVECOUNT-1:0] SLAVEBASE_FLAT =
    {ADDRBITSZ'(32'h100), ADDRBITSZ'(32'h0)},
  parameter logic [ADDRBITSZ*SLAVECOUNT-1:0] SLAVESIZE_FLAT =
    {ADDRBITSZ'(32'h40), ADDRBITSZ'(32'h100)}
) (
  input  logic    clk_i,
  input  logic    rst_i,
  pi1dcd_if.slave bus
);

  localparam int unsigned PRVBITSZ = clog2(SLAVECOUNT + 1);
  localparam logic [PRVBITSZ-1:0] MISS = PRVBITSZ'(SLAVECOUNT);

  logic [SLAVECOUNT-1:0]           hit;
  logic [ADDRBITSZ-1:0]            rebased [SLAVECOUNT];
  logic [PRVBITSZ-1:0]             cur;
  logic [PRVBITSZ-1:0]             prv;
  logic                            rdyprv;
  logic                            rdycur;
  logic                            is_op;
  logic                            issue;
  logic                            rdy;
  logic                            accept;
  logic                            err;
  logic [ADDRBITSZ-1:0]            erraddr;
  logic [ARCHBITSZ-1:0]            data;
  logic [2*SLAVECOUNT-1:0]         s_op;
  logic [ADDRBITSZ*SLAVECOUNT-1:0] s_addr;

  for (genvar i = 0; i < SLAVECOUNT; i++) begin : g_match
    pi1dcd_match #(
      .ADDRBITSZ(ADDRBITSZ)
    ) u_match (
      .addr    (bus.m_addr_i),
      .base    (SLAVEBASE_FLAT[i*ADDRBITSZ +: ADDRBITSZ]),
      .size    (SLAVESIZE_FLAT[i*ADDRBITSZ +: ADDRBITSZ]),
      .hit     (hit[i]),
      .rebased (rebased[i])
    );
  end

  // Priority encoder: scanning downward leaves the lowest hit index in cur.
  always_comb begin
    cur = MISS;
    for (int unsigned i = SLAVECOUNT; i > 0; i--) begin
      if (hit[i-1]) cur = PRVBITSZ'(i - 1);
    end
  end

  // A miss target behaves as an always-ready slave returning zero.
  always_comb begin
    rdyprv = 1'b1;
    rdycur = 1'b1;
    data   = '0;
    for (int unsigned i = 0; i < SLAVECOUNT; i++) begin
      if (prv == PRVBITSZ'(i)) begin
        rdyprv = bus.s_rdy_i_flat[i];
        data   = bus.s_data_i_flat[i*ARCHBITSZ +: ARCHBITSZ];
      end
      if (cur == PRVBITSZ'(i)) rdycur = bus.s_rdy_i_flat[i];
    end
    is_op  = (bus.m_op_i != PINOOP);
    rdy    = rdyprv && (!is_op || rdycur);
    accept = rdy && is_op;
    issue  = is_op && (rdyprv || (prv == cur));
    s_op   = '0;
    s_addr = '0;
    for (int unsigned i = 0; i < SLAVECOUNT; i++) begin
      if (issue && (cur == PRVBITSZ'(i))) s_op[2*i +: 2] = bus.m_op_i;
      s_addr[i*ADDRBITSZ +: ADDRBITSZ] = rebased[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prv     <= MISS;
      err     <= 1'b0;
      erraddr <= '0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        prv <= cur;
        if (cur == MISS) begin
          err     <= 1'b1;
          erraddr <= bus.m_addr_i;
        end
      end
    end
  end

  assign bus.m_data_o      = data;
  assign bus.m_rdy_o       = rdy;
  assign bus.s_op_o_flat   = s_op;
  assign bus.s_addr_o_flat = s_addr;
  assign bus.s_data_o_flat = {SLAVECOUNT{bus.m_data_i}};
  assign bus.s_sel_o_flat  = {SLAVECOUNT{bus.m_sel_i}};
  assign bus.err_o         = err;
  assign bus.erraddr_o     = erraddr;

endmodule

// File: tb/tb_pi1dcd.sv
// Bench for pi1dcd: two instances (default windows, and slave1 disabled)
// compared every cycle against a window/pending-slave reference model.
module tb_pi1dcd;
  import pi1dcd_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pi1dcd_if #(.SLAVECOUNT(2), .ARCHBITSZ(32)) bus0 ();
  pi1dcd_if #(.SLAVECOUNT(2), .ARCHBITSZ(32)) bus1 ();

  pi1dcd #(
    .SLAVECOUNT(2), .ARCHBITSZ(32),
    .SLAVEBASE_FLAT({30'h100, 30'h0}),
    .SLAVESIZE_FLAT({30'h40, 30'h100})
  ) u_dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus0));

  pi1dcd #(
    .SLAVECOUNT(2), .ARCHBITSZ(32),
    .SLAVEBASE_FLAT({30'h100, 30'h0}),
    .SLAVESIZE_FLAT({30'h0, 30'h100})
  ) u_dut_nos1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));

  logic [1:0]  op;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [1:0]  srdy;
  logic [31:0] sdata [2];

  assign bus0.m_op_i = op;        assign bus1.m_op_i = op;
  assign bus0.m_addr_i = addr;    assign bus1.m_addr_i = addr;
  assign bus0.m_data_i = wdata;   assign bus1.m_data_i = wdata;
  assign bus0.m_sel_i = sel;      assign bus1.m_sel_i = sel;
  assign bus0.s_rdy_i_flat = srdy;
  assign bus1.s_rdy_i_flat = srdy;
  assign bus0.s_data_i_flat = {sdata[1], sdata[0]};
  assign bus1.s_data_i_flat = {sdata[1], sdata[0]};

  localparam logic [29:0] BASE [2]    = '{30'h0, 30'h100};
  localparam logic [29:0] SIZE [2][2] = '{'{30'h100, 30'h40}, '{30'h100, 30'h0}};

  // Model state per instance: pending slave (2 = none/miss), error pulse, last miss.
  int unsigned mprv [2];
  logic        merr [2];
  logic [29:0] merra [2];

  int unsigned n_checks;
  int unsigned n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned decode(input int unsigned k, input logic [29:0] a);
    for (int unsigned i = 0; i < 2; i++) begin
      if (30'(a - BASE[i]) < SIZE[k][i]) return i;
    end
    return 2;
  endfunction

  task automatic step(input logic do_rst);
    int unsigned cur [2];
    logic        acc [2];
    logic        isop, rdyprv, exp_rdy;
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
    logic        obs_rdy, obs_err;
    logic [31:0] obs_data;
    logic [29:0] obs_erra;
    logic [3:0]  obs_sop;
    logic [59:0] obs_saddr;
    logic [63:0] obs_sd;
    logic [7:0]  obs_ss;
    rst_i = do_rst;
    #2;
    for (int unsigned k = 0; k < 2; k++) begin
      obs_rdy   = (k == 0) ? bus0.m_rdy_o       : bus1.m_rdy_o;
      obs_data  = (k == 0) ? bus0.m_data_o      : bus1.m_data_o;
      obs_err   = (k == 0) ? bus0.err_o         : bus1.err_o;
      obs_erra  = (k == 0) ? bus0.erraddr_o     : bus1.erraddr_o;
      obs_sop   = (k == 0) ? bus0.s_op_o_flat   : bus1.s_op_o_flat;
      obs_saddr = (k == 0) ? bus0.s_addr_o_flat : bus1.s_addr_o_flat;
      obs_sd    = (k == 0) ? bus0.s_data_o_flat : bus1.s_data_o_flat;
      obs_ss    = (k == 0) ? bus0.s_sel_o_flat  : bus1.s_sel_o_flat;
      cur[k]   = decode(k, addr);
      isop     = (op != 2'b00);
      rdyprv   = (mprv[k] == 2) ? 1'b1 : srdy[mprv[k]];
      exp_rdy  = rdyprv && (!isop || cur[k] == 2 || srdy[cur[k]]);
      exp_data = (mprv[k] == 2) ? 32'h0 : sdata[mprv[k]];
      acc[k]   = exp_rdy && isop;
      check($sformatf("dut%0d m_rdy", k), 64'(obs_rdy), 64'(exp_rdy));
      check($sformatf("dut%0d m_data", k), 64'(obs_data), 64'(exp_data));
      check($sformatf("dut%0d err", k), 64'(obs_err), 64'(merr[k]));
      check($sformatf("dut%0d erraddr", k), 64'(obs_erra), 64'(merra[k]));
      for (int unsigned i = 0; i < 2; i++) begin
        exp_op = (isop && cur[k] == i && (rdyprv || mprv[k] == cur[k])) ? op : 2'b00;
        check($sformatf("dut%0d s_op[%0d]", k, i), 64'(obs_sop[2*i +: 2]), 64'(exp_op));
        check($sformatf("dut%0d s_addr[%0d]", k, i), 64'(obs_saddr[30*i +: 30]),
              64'(30'(addr - BASE[i])));
      end
      check($sformatf("dut%0d s_data", k), obs_sd, {wdata, wdata});
      check($sformatf("dut%0d s_sel", k), 64'(obs_ss), 64'({sel, sel}));
    end
    @(posedge clk_i);
    for (int unsigned k = 0; k < 2; k++) begin
      if (do_rst) begin
        mprv[k] = 2; merr[k] = 1'b0; merra[k] = '0;
      end else begin
        merr[k] = 1'b0;
        if (acc[k]) begin
          mprv[k] = cur[k];
          if (cur[k] == 2) begin
            merr[k]  = 1'b1;
            merra[k] = addr;
          end
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [1:0] o, input logic [29:0] a, input logic [1:0] r);
    op    = o;
    addr  = a;
    srdy  = r;
    wdata = $urandom;
    sel   = 4'($urandom);
  endtask

  initial begin
    logic [29:0] edges [6];
    edges = '{30'h0FF, 30'h100, 30'h13F, 30'h140, 30'h3FFFFFFF, 30'h0};
    n_checks = 0;
    n_errors = 0;
    op = 2'b00; addr = '0; wdata = '0; sel = '0; srdy = 2'b11;
    sdata[0] = '0; sdata[1] = '0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    for (int unsigned k = 0; k < 2; k++) begin
      mprv[k] = 2; merr[k] = 1'b0; merra[k] = '0;
    end

    // Idle after reset.
    drive(2'b00, 30'h0, 2'b11);
    step(1'b0);

    // RD to slave1, data returned the following cycle.
    drive(2'b10, 30'h105, 2'b11);
    step(1'b0);
    drive(2'b00, 30'h0, 2'b11);
    sdata[1] = 32'hCAFEF00D;
    #1;
    check("rd data", 64'(bus0.m_data_o), 64'h0000_0000_CAFE_F00D);
    step(1'b0);

    // WR to slave0, then RD to slave1 held off while slave0 is busy.
    drive(2'b01, 30'h010, 2'b11);
    step(1'b0);
    for (int unsigned c = 0; c < 3; c++) begin
      drive(2'b10, 30'h120, 2'b10);
      step(1'b0);
    end
    drive(2'b10, 30'h120, 2'b11);
    step(1'b0);

    // Miss: accepted at once, error pulse on the next cycle only.
    drive(2'b10, 30'h200, 2'b11);
    step(1'b0);
    drive(2'b00, 30'h0, 2'b11);
    #1;
    check("miss err", 64'(bus0.err_o), 64'h1);
    check("miss erraddr", 64'(bus0.erraddr_o), 64'h200);
    step(1'b0);
    step(1'b0);

    // Disabled slave1 turns 0x100 into a miss on the second instance.
    drive(2'b10, 30'h100, 2'b11);
    step(1'b0);
    drive(2'b00, 30'h0, 2'b11);
    #1;
    check("nos1 err", 64'(bus1.err_o), 64'h1);
    check("nos1 erraddr", 64'(bus1.erraddr_o), 64'h100);
    step(1'b0);

    // Reset while slave1 response is outstanding.
    drive(2'b10, 30'h105, 2'b11);
    step(1'b0);
    drive(2'b00, 30'h0, 2'b01);
    step(1'b0);
    step(1'b1);
    #1;
    check("rst rdy", 64'(bus0.m_rdy_o), 64'h1);
    check("rst data", 64'(bus0.m_data_o), 64'h0);
    step(1'b0);

    // Random traffic.
    for (int unsigned n = 0; n < 3000; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: addr = 30'($urandom_range(0, 255));
        1: addr = 30'h100 + 30'($urandom_range(0, 63));
        2: addr = edges[$urandom_range(0, 5)];
        default: addr = 30'($urandom);
      endcase
      wdata    = $urandom;
      sel      = 4'($urandom);
      srdy[0]  = ($urandom_range(0, 3) != 0);
      srdy[1]  = ($urandom_range(0, 3) != 0);
      sdata[0] = $urandom;
      sdata[1] = $urandom;
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
